pipe_datapath: RTL

Parametrised two-stage successor to the single-cycle register-file/ALU datapath. It holds NREGS general registers of WIDTH bits, captures operands in a stage-1 pipeline register, and executes and writes back in stage 2. It adds an operand bypass, a sign-extended immediate operand, a persistent flags register that feeds add-with-carry, and a debug read port. It sits between instruction decode and the memory/IO interface of the CPU.

---
 rtl/pipe_dp_pkg.sv | 31 +++
 rtl/dp_alu.sv | 73 +++++++
 rtl/pipe_datapath.sv | 96 +++++++++
 3 files changed

// File: rtl/pipe_dp_pkg.sv
// Shared definitions for the two-stage register-file/ALU datapath:
// opcode values, flag bit positions and the writeback predicate.
package pipe_dp_pkg;

  typedef logic [3:0] opcode_t;
  typedef logic [4:0] flags_t;

  localparam opcode_t OP_ADD  = 4'h0;
  localparam opcode_t OP_ADDC = 4'h1;
  localparam opcode_t OP_SUB  = 4'h2;
  localparam opcode_t OP_CMP  = 4'h3;
  localparam opcode_t OP_AND  = 4'h4;
  localparam opcode_t OP_OR   = 4'h5;
  localparam opcode_t OP_XOR  = 4'h6;
  localparam opcode_t OP_MOV  = 4'h7;
  localparam opcode_t OP_LSL  = 4'h8;
  localparam opcode_t OP_LSR  = 4'h9;
  localparam opcode_t OP_ASR  = 4'hA;

  localparam int FLAG_C = 4;
  localparam int FLAG_L = 3;
  localparam int FLAG_F = 2;
  localparam int FLAG_Z = 1;
  localparam int FLAG_N = 0;

  // CMP and the 0xB-0xF no-ops never touch the register file.
  function automatic logic op_writes(input opcode_t op);
    return (op <= OP_ASR) && (op != OP_CMP);
  endfunction

endpackage

// File: rtl/dp_alu.sv
// Combinational ALU: result, candidate flags, and a per-flag update mask
// telling the flags register which bits this opcode is allowed to change.
module dp_alu
  import pipe_dp_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  opcode_t          op,
  input  logic             cin,
  output logic [WIDTH-1:0] y,
  output flags_t           flags,
  output flags_t           upd
);

  logic [WIDTH:0] sum;
  logic [WIDTH:0] diff;
  logic           is_sub;
  logic           slt;

  always_comb begin
    sum    = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, (op == OP_ADDC) & cin};
    diff   = {1'b0, a} - {1'b0, b};
    is_sub = (op == OP_SUB) || (op == OP_CMP);
    // Signed A<B: differing signs decide directly, otherwise the difference cannot overflow.
    slt    = (a[WIDTH-1] != b[WIDTH-1]) ? a[WIDTH-1] : diff[WIDTH-1];
    y      = '0;
    flags  = '0;
    upd    = '0;
    case (op)
      OP_ADD, OP_ADDC: begin
        y             = sum[WIDTH-1:0];
        flags[FLAG_C] = sum[WIDTH];
        flags[FLAG_F] = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
        upd           = 5'b10111;
      end
      OP_SUB, OP_CMP: begin
        y             = diff[WIDTH-1:0];
        flags[FLAG_C] = diff[WIDTH];
        flags[FLAG_L] = diff[WIDTH];
        flags[FLAG_F] = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
        upd           = 5'b11111;
      end
      OP_AND: begin y = a & b; upd = 5'b00011; end
      OP_OR:  begin y = a | b; upd = 5'b00011; end
      OP_XOR: begin y = a ^ b; upd = 5'b00011; end
      OP_MOV: begin y = b;     upd = 5'b00011; end
      OP_LSL: begin
        y             = {a[WIDTH-2:0], 1'b0};
        flags[FLAG_C] = a[WIDTH-1];
        upd           = 5'b10011;
      end
      OP_LSR: begin
        y             = {1'b0, a[WIDTH-1:1]};
        flags[FLAG_C] = a[0];
        upd           = 5'b10011;
      end
      OP_ASR: begin
        y             = {a[WIDTH-1], a[WIDTH-1:1]};
        flags[FLAG_C] = a[0];
        upd           = 5'b10011;
      end
      default: begin
        y   = '0;
        upd = '0;
      end
    endcase
    flags[FLAG_Z] = (y == '0);
    flags[FLAG_N] = is_sub ? slt : y[WIDTH-1];
  end

endmodule

// File: rtl/pipe_datapath.sv
// Two-stage datapath: stage 1 captures operands (with bypass from stage 2),
// stage 2 executes, writes back and commits Result/Flags.
module pipe_datapath
  import pipe_dp_pkg::*;
#(
  parameter  int WIDTH = 16,
  parameter  int NREGS = 16,
  localparam int AW    = $clog2(NREGS)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic [3:0]       op,
  input  logic [AW-1:0]    reg_a,
  input  logic [AW-1:0]    reg_b,
  input  logic [7:0]       imm,
  input  logic             use_imm,
  input  logic             wr_en,
  input  logic [AW-1:0]    dbg_sel,
  output logic [WIDTH-1:0] dbg_data,
  output logic [WIDTH-1:0] result,
  output logic             out_valid,
  output logic [4:0]       flags
);

  logic [WIDTH-1:0] regs [NREGS];

  logic             s1_valid;
  opcode_t          s1_op;
  logic             s1_wr_en;
  logic [AW-1:0]    s1_dst;
  logic [WIDTH-1:0] s1_a;
  logic [WIDTH-1:0] s1_b;

  logic [WIDTH-1:0] alu_y;
  flags_t           alu_flags;
  flags_t           alu_upd;
  logic             wb;
  logic [WIDTH-1:0] imm_ext;
  logic [WIDTH-1:0] opnd_a;
  logic [WIDTH-1:0] opnd_b;

  dp_alu #(.WIDTH(WIDTH)) u_alu (
    .a     (s1_a),
    .b     (s1_b),
    .op    (s1_op),
    .cin   (flags[FLAG_C]),
    .y     (alu_y),
    .flags (alu_flags),
    .upd   (alu_upd)
  );

  assign wb       = s1_valid && s1_wr_en && op_writes(s1_op);
  assign imm_ext  = WIDTH'($signed(imm));
  assign dbg_data = regs[dbg_sel];

  // The register being written this edge is read from the ALU, not the array.
  assign opnd_a = (wb && (s1_dst == reg_a)) ? alu_y : regs[reg_a];
  assign opnd_b = use_imm                   ? imm_ext :
                  (wb && (s1_dst == reg_b)) ? alu_y : regs[reg_b];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
    end else if (wb) begin
      regs[s1_dst] <= alu_y;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_valid  <= 1'b0;
      s1_op     <= '0;
      s1_wr_en  <= 1'b0;
      s1_dst    <= '0;
      s1_a      <= '0;
      s1_b      <= '0;
      result    <= '0;
      flags     <= '0;
      out_valid <= 1'b0;
    end else begin
      s1_valid  <= in_valid;
      s1_op     <= op;
      s1_wr_en  <= wr_en;
      s1_dst    <= reg_a;
      s1_a      <= opnd_a;
      s1_b      <= opnd_b;
      out_valid <= s1_valid;
      if (s1_valid) begin
        result <= alu_y;
        flags  <= (alu_upd & alu_flags) | (~alu_upd & flags);
      end
    end
  end

endmodule
